// File: rtl/seq_sched_pkg.sv
// seq_sched_pkg: shared types and helpers for the seq_sched scheduler.
//   state_t  - scheduler FSM states (3-bit encoding)
//   ID_W_MAX - width of a requester id at the largest supported NREQ
//   rr_pick  - round-robin search: first set valid bit after ptr, modulo n
package seq_sched_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    RESP  = 3'd4
  } state_t;

  localparam int unsigned NREQ_MAX = 8;
  localparam int unsigned ID_W_MAX = $clog2(NREQ_MAX);

  typedef struct packed {
    logic                found;
    logic [ID_W_MAX-1:0] idx;
  } pick_t;

  // Searches ptr+1, ptr+2, ... wrapping at n; first valid requester wins.
  function automatic pick_t rr_pick(input logic [NREQ_MAX-1:0] valid,
                                    input int unsigned          n,
                                    input int unsigned          ptr);
    pick_t       r;
    int unsigned c;
    r = '0;
    for (int unsigned k = 1; k <= NREQ_MAX; k++) begin
      if (k <= n) begin
        c = ptr + k;
        if (c >= n) c = c - n;
        if (!r.found && valid[c[ID_W_MAX-1:0]]) begin
          r.found = 1'b1;
          r.idx   = c[ID_W_MAX-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_sched_rr_arb.sv
// seq_sched_rr_arb: combinational NREQ-wide round-robin arbiter.
// Ports:
//   req_valid - per-requester request
//   ptr       - id of the last granted requester (search starts at ptr+1)
//   grant     - one-hot grant, all zero when nobody requests
//   gnt_id    - encoded id of the granted requester (0 when none)
module seq_sched_rr_arb
  import seq_sched_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned ID_W = 1
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] gnt_id
);

  logic [NREQ_MAX-1:0] valid_ext;
  pick_t               pick;

  always_comb begin
    valid_ext             = '0;
    valid_ext[NREQ-1:0]   = req_valid;
    pick                  = rr_pick(valid_ext, NREQ, 32'(ptr));
    grant                 = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      grant[i] = pick.found && (32'(pick.idx) == i);
    end
    gnt_id = ID_W'(pick.idx);
  end

endmodule

// File: rtl/seq_sched.sv
// seq_sched: round-robin scheduler sharing one serial sequence detector
// between NREQ requesters. A granted word is framed as CLR (detector clear),
// WORD_W SHIFT cycles, one DRAIN cycle, then a RESP handshake carrying the
// saturating count of z-high samples and the owner id.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   req_valid/req_data  - per-requester word offer (word i at [i*WORD_W +: WORD_W])
//   req_ready           - one-hot accept, combinational, only in IDLE
//   det_x, det_clr      - registered detector drive
//   det_z               - detector Moore output for the previous bit
//   rsp_valid/rsp_ready - response handshake; rsp_id, rsp_hits held in RESP
//   busy                - high outside IDLE
// Build option: define SEQ_SCHED_LSB_FIRST_EN to shift bit 0 first instead of MSB first.
module seq_sched
  import seq_sched_pkg::*;
#(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned WORD_W = 4,
  parameter int unsigned CNT_W  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*WORD_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     det_x,
  output logic                     det_clr,
  input  logic                     det_z,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [CNT_W-1:0]         rsp_hits,
  output logic                     busy
);

  localparam int unsigned ID_W  = $clog2(NREQ);
  localparam int unsigned IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  state_t              state_q;
  logic [ID_W-1:0]     ptr_q;
  logic [ID_W-1:0]     id_q;
  logic [WORD_W-1:0]   word_q;
  logic [IDX_W-1:0]    idx_q;
  logic [CNT_W-1:0]    hits_q;
  logic                det_x_q;
  logic                det_clr_q;
  logic                rsp_valid_q;

  logic [NREQ-1:0]     grant;
  logic [ID_W-1:0]     gnt_id;
  logic [WORD_W-1:0]   sel_word;
  logic [WORD_W-1:0]   word_d;
  logic                bit_d;
  logic [CNT_W-1:0]    hits_d;

  seq_sched_rr_arb #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .gnt_id    (gnt_id)
  );

  // Gated by rst so no accept is advertised while reset is held.
  assign req_ready = (state_q == IDLE && !rst) ? grant : '0;

  always_comb begin
    sel_word = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) sel_word = req_data[i*WORD_W +: WORD_W];
    end
  end

  // The word register doubles as the shift register; the outgoing bit is
  // always taken from the same end.
`ifdef SEQ_SCHED_LSB_FIRST_EN
  assign bit_d  = word_q[0];
  assign word_d = word_q >> 1;
`else
  assign bit_d  = word_q[WORD_W-1];
  assign word_d = word_q << 1;
`endif

  assign hits_d = (det_z && hits_q != '1) ? hits_q + 1'b1 : hits_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= ID_W'(NREQ-1);
      id_q        <= '0;
      word_q      <= '0;
      idx_q       <= '0;
      hits_q      <= '0;
      det_x_q     <= 1'b0;
      det_clr_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          det_x_q   <= 1'b0;
          det_clr_q <= 1'b0;
          if (|grant) begin
            word_q    <= sel_word;
            id_q      <= gnt_id;
            ptr_q     <= gnt_id;
            hits_q    <= '0;
            det_clr_q <= 1'b1;
            state_q   <= CLR;
          end
        end
        CLR: begin
          det_clr_q <= 1'b0;
          det_x_q   <= bit_d;
          word_q    <= word_d;
          idx_q     <= '0;
          state_q   <= SHIFT;
        end
        SHIFT: begin
          // z in the first SHIFT cycle still reflects the cleared detector.
          if (idx_q != '0) hits_q <= hits_d;
          if (idx_q == IDX_W'(WORD_W-1)) begin
            det_x_q <= 1'b0;
            state_q <= DRAIN;
          end else begin
            det_x_q <= bit_d;
            word_q  <= word_d;
            idx_q   <= idx_q + 1'b1;
          end
        end
        DRAIN: begin
          hits_q      <= hits_d;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          det_x_q     <= 1'b0;
          det_clr_q   <= 1'b0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign det_x     = det_x_q;
  assign det_clr   = det_clr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_hits  = hits_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_seq_sched.sv
module tb_seq_sched;

  localparam int unsigned NREQ   = 2;
  localparam int unsigned WORD_W = 4;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned SATV   = (1 << CNT_W) - 1;

  logic                    clk;
  logic                    rst;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ*WORD_W-1:0]  req_data;
  logic [NREQ-1:0]         req_ready;
  logic                    det_x;
  logic                    det_clr;
  logic                    det_z;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [0:0]              rsp_id;
  logic [CNT_W-1:0]        rsp_hits;
  logic                    busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int exp_ptr;

  seq_sched #(
    .NREQ   (NREQ),
    .WORD_W (WORD_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .det_x     (det_x),
    .det_clr   (det_clr),
    .det_z     (det_z),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_hits  (rsp_hits),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: first valid requester after ptr, wrapping.
  function automatic int model_grant(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 0);
    chk({tag, "_det_x"},     32'(det_x), 0);
    chk({tag, "_det_clr"},   32'(det_clr), 0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_id"},    32'(rsp_id), 0);
    chk({tag, "_rsp_hits"},  32'(rsp_hits), 0);
    chk({tag, "_busy"},      32'(busy), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    exp_ptr = NREQ - 1;
  endtask

  // One transaction relative to the accept cycle (cycle 0): CLR at 1, SHIFT 2..5,
  // DRAIN 6, RESP from 7. zv[c] is det_z during cycle c; samples land in 3..6.
  task automatic do_word(input logic [NREQ-1:0] valid, input logic [3:0] w0, input logic [3:0] w1,
                         input logic [6:0] zv, input int unsigned rdly, input int unsigned abort_c,
                         output int rcyc);
    int          id;
    logic [3:0]  w;
    int unsigned zcnt;
    int          eb;
    rcyc = -1;
    @(negedge clk);
    req_valid = valid; req_data = {w1, w0}; det_z = zv[0]; rsp_ready = 1'b0;
    #1;
    id = model_grant(valid, exp_ptr);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_rsp_valid", 32'(rsp_valid), 0);
    if (id < 0) begin
      chk("idle_no_ready", 32'(req_ready), 0);
      return;
    end
    chk("grant", 32'(req_ready), 32'(1 << id));
    exp_ptr = id;
    w = (id == 0) ? w0 : w1;
    zcnt = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      req_valid = NREQ'($urandom); det_z = zv[c];
      #1;
      if (c >= 2 && c <= 5) begin
`ifdef SEQ_SCHED_LSB_FIRST_EN
        eb = int'(w[c-2]);
`else
        eb = int'(w[5-c]);
`endif
      end else begin
        eb = 0;
      end
      chk($sformatf("det_clr_c%0d", c), 32'(det_clr), (c == 1) ? 1 : 0);
      chk($sformatf("det_x_c%0d", c), 32'(det_x), 32'(eb));
      chk($sformatf("busy_c%0d", c), 32'(busy), 1);
      chk($sformatf("ready_c%0d", c), 32'(req_ready), 0);
      chk($sformatf("rsp_valid_c%0d", c), 32'(rsp_valid), 0);
      if (c >= 3 && zv[c]) zcnt++;
      if (c == abort_c) begin
        rst = 1'b1;
        #1;
        chk_all_zero("abort");
        @(negedge clk);
        rst = 1'b0; req_valid = '0;
        exp_ptr = NREQ - 1;
        return;
      end
    end
    if (zcnt > SATV) zcnt = SATV;
    for (int unsigned d = 0; d <= rdly; d++) begin
      @(negedge clk);
      rsp_ready = (d == rdly); req_valid = NREQ'($urandom); det_z = 1'($urandom);
      #1;
      if (d == 0) rcyc = cyc;
      chk("rsp_valid", 32'(rsp_valid), 1);
      chk("rsp_id", 32'(rsp_id), 32'(id));
      chk("rsp_hits", 32'(rsp_hits), 32'(zcnt));
      chk("rsp_no_ready", 32'(req_ready), 0);
      chk("rsp_busy", 32'(busy), 1);
    end
  endtask

  initial begin
    int r0, r1;
    rst = 1'b0; req_valid = '1; req_data = '0; det_z = 1'b0; rsp_ready = 1'b0;
    exp_ptr = NREQ - 1;
    #2 rst = 1'b1;
    #2;
    chk_all_zero("rst_early");
    @(negedge clk); @(negedge clk);
    #1;
    chk_all_zero("rst_held");
    @(negedge clk);
    rst = 1'b0; req_valid = '0;

    // First grant after reset goes to requester 0; two z-high samples.
    do_word(2'b11, 4'b1011, 4'b0110, 7'b0011000, 0, 0, r0);

    // Continuous requests alternate, responses 8 cycles apart.
    do_reset();
    do_word(2'b11, 4'b1001, 4'b1110, 7'($urandom), 0, 0, r0);
    for (int i = 0; i < 3; i++) begin
      do_word(2'b11, 4'b1001, 4'b1110, 7'($urandom), 0, 0, r1);
      chk("rsp_spacing", 32'(r1 - r0), 8);
      r0 = r1;
    end

    // Saturation, and z outside the sampling window ignored.
    do_word(2'b01, 4'b1111, 4'b0000, 7'b1111111, 0, 0, r0);
    do_word(2'b10, 4'b0101, 4'b1010, 7'b0000111, 0, 0, r0);

    // Backpressure holds the response.
    do_word(2'b11, 4'b0011, 4'b1100, 7'b1001000, 5, 0, r0);

    // Reset during the third SHIFT cycle, then a fresh word.
    do_word(2'b10, 4'b0111, 4'b1101, 7'b1111111, 0, 4, r0);
    do_word(2'b11, 4'b1101, 4'b0010, 7'b0101000, 0, 0, r0);

    // Randomized traffic.
    for (int i = 0; i < 24; i++) begin
      do_word(NREQ'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), 7'($urandom),
              $urandom_range(0, 2), 0, r0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
